// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
//
// Arbitrates cache-line read requests from the instruction cache and the data
// cache onto a single memory read port. At most one memory transaction is
// outstanding. Simultaneous requests are resolved round-robin, and the pointer
// favours the icache out of reset.
//
// Ports
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   icache_req / dcache_req   : line-read request, held until the matching addr_ok
//   icache_addr / dcache_addr : request physical address
//   icache_addr_ok / dcache_addr_ok     : one-cycle address-accepted pulse
//   icache_return_en / dcache_return_en : one-cycle line-valid pulse
//   icache_return_data / dcache_return_data : returned line, zero when not valid
//   mem_read_request, mem_read_addr     : line-aligned read request to memory
//   mem_ready_to_read, mem_read_addr_ok : memory must raise both to accept
//   mem_return_en, mem_return_data      : line return from memory
//   busy        : transaction in flight (ADDR or DATA)
//   grant_id    : current owner (0 = icache, 1 = dcache), 0 when idle
//   timeout_err : sticky, set when a DATA wait reaches TIMEOUT cycles
// ---------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  icache_req,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_addr_ok,
    output logic                  icache_return_en,
    output logic [LINE_WIDTH-1:0] icache_return_data,

    input  logic                  dcache_req,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    output logic                  dcache_addr_ok,
    output logic                  dcache_return_en,
    output logic [LINE_WIDTH-1:0] dcache_return_data,

    output logic                  mem_read_request,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic                  mem_ready_to_read,
    input  logic                  mem_read_addr_ok,
    input  logic                  mem_return_en,
    input  logic [LINE_WIDTH-1:0] mem_return_data,

    output logic                  busy,
    output logic                  grant_id,
    output logic                  timeout_err
);

    localparam int                    OFFSET      = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK   = {ADDR_WIDTH{1'b1}} << OFFSET;
    localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    // Id favoured when both caches request together: the one not served last.
    logic                  prio_q,  prio_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]            wait_q,  wait_d;
    logic                  err_q,   err_d;

    logic accept;
    logic ret;
    logic winner;

    always_comb begin
        accept = (state_q == S_ADDR) && mem_ready_to_read && mem_read_addr_ok;
        ret    = (state_q == S_DATA) && mem_return_en;
        // A lone dcache request wins; a lone icache request yields 0.
        winner = (icache_req && dcache_req) ? prio_q : dcache_req;

        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (icache_req || dcache_req) begin
                    grant_d = winner;
                    addr_d  = (winner ? dcache_addr : icache_addr) & LINE_MASK;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    state_d = S_DATA;
                    wait_d  = '0;
                end
            end
            S_DATA: begin
                if (mem_return_en) begin
                    state_d = S_IDLE;
                    prio_d  = ~grant_q;
                end else begin
                    if (wait_q != 8'hFF) begin
                        wait_d = wait_q + 8'd1;
                    end
                    if (wait_d >= TIMEOUT_CNT) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Handshake and return outputs are combinational so the caches see them
    // in the same cycle memory responds.
    always_comb begin
        busy             = (state_q != S_IDLE);
        grant_id         = busy & grant_q;
        mem_read_request = (state_q == S_ADDR);
        mem_read_addr    = mem_read_request ? addr_q : '0;
        timeout_err      = err_q;

        icache_addr_ok   = accept & ~grant_q;
        dcache_addr_ok   = accept &  grant_q;

        icache_return_en = ret & ~grant_q;
        dcache_return_en = ret &  grant_q;

        icache_return_data = icache_return_en ? mem_return_data : '0;
        dcache_return_data = dcache_return_en ? mem_return_data : '0;
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 10;

    logic          clk;
    logic          rst_n;
    logic          icache_req, dcache_req;
    logic [AW-1:0] icache_addr, dcache_addr;
    logic          icache_addr_ok, dcache_addr_ok;
    logic          icache_return_en, dcache_return_en;
    logic [LW-1:0] icache_return_data, dcache_return_data;
    logic          mem_read_request;
    logic [AW-1:0] mem_read_addr;
    logic          mem_ready_to_read, mem_read_addr_ok, mem_return_en;
    logic [LW-1:0] mem_return_data;
    logic          busy, grant_id, timeout_err;

    mem_read_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .TIMEOUT   (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .icache_req         (icache_req),
        .icache_addr        (icache_addr),
        .icache_addr_ok     (icache_addr_ok),
        .icache_return_en   (icache_return_en),
        .icache_return_data (icache_return_data),
        .dcache_req         (dcache_req),
        .dcache_addr        (dcache_addr),
        .dcache_addr_ok     (dcache_addr_ok),
        .dcache_return_en   (dcache_return_en),
        .dcache_return_data (dcache_return_data),
        .mem_read_request   (mem_read_request),
        .mem_read_addr      (mem_read_addr),
        .mem_ready_to_read  (mem_ready_to_read),
        .mem_read_addr_ok   (mem_read_addr_ok),
        .mem_return_en      (mem_return_en),
        .mem_return_data    (mem_return_data),
        .busy               (busy),
        .grant_id           (grant_id),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit exp_err = 1'b0;

    typedef struct {
        logic          id;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } exp_t;
    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [AW-1:0] addr, input logic [LW-1:0] line);
        exp_t e;
        e.id   = id;
        e.addr = addr;
        e.line = line;
        sb.push_back(e);
    endtask

    // Plays the memory side for one transaction and checks it against the
    // oldest scoreboard entry.
    task automatic serve(input bit keep_req, input int stall, input int wait_data);
        exp_t e;
        int   n;
        n = 0;
        while (!mem_read_request && n < 20) begin
            tick();
            n++;
        end
        chk("addr_phase_seen", LW'(mem_read_request), 1);
        if (!mem_read_request) return;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("grant_id", LW'(grant_id), LW'(e.id));
        chk("read_addr", LW'(mem_read_addr), LW'(e.addr));
        chk("busy_addr", LW'(busy), 1);
        if (!keep_req) begin
            if (e.id) dcache_req = 1'b0;
            else      icache_req = 1'b0;
        end
        mem_read_addr_ok  = 1'b1;
        mem_ready_to_read = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_no_ack", LW'({icache_addr_ok, dcache_addr_ok}), 0);
            chk("stall_req_held", LW'(mem_read_request), 1);
            chk("stall_addr_held", LW'(mem_read_addr), LW'(e.addr));
            tick();
        end
        mem_ready_to_read = 1'b1;
        #1;
        chk("addr_ok_granted", LW'(e.id ? dcache_addr_ok : icache_addr_ok), 1);
        chk("addr_ok_other", LW'(e.id ? icache_addr_ok : dcache_addr_ok), 0);
        tick();
        mem_ready_to_read = 1'b0;
        mem_read_addr_ok  = 1'b0;
        for (int k = 0; k < wait_data; k++) begin
            #1;
            if (k >= TO) exp_err = 1'b1;
            chk("wait_no_ret", LW'({icache_return_en, dcache_return_en}), 0);
            chk("timeout_err_wait", LW'(timeout_err), LW'(exp_err));
            tick();
        end
        mem_return_en   = 1'b1;
        mem_return_data = e.line;
        #1;
        if (wait_data >= TO) exp_err = 1'b1;
        chk("ret_en", LW'(e.id ? dcache_return_en : icache_return_en), 1);
        chk("ret_data", e.id ? dcache_return_data : icache_return_data, e.line);
        chk("other_ret_en", LW'(e.id ? icache_return_en : dcache_return_en), 0);
        chk("other_ret_data", e.id ? icache_return_data : dcache_return_data, 0);
        chk("timeout_err_ret", LW'(timeout_err), LW'(exp_err));
        tick();
        mem_return_en   = 1'b0;
        mem_return_data = '0;
        #1;
        chk("idle_after_ret", LW'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        icache_req        = 1'b0;
        dcache_req        = 1'b0;
        icache_addr       = '0;
        dcache_addr       = '0;
        mem_ready_to_read = 1'b0;
        mem_read_addr_ok  = 1'b0;
        mem_return_en     = 1'b0;
        mem_return_data   = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", LW'(busy), 0);
        chk("rst_req", LW'(mem_read_request), 0);
        chk("rst_addr", LW'(mem_read_addr), 0);
        chk("rst_grant", LW'(grant_id), 0);
        chk("rst_err", LW'(timeout_err), 0);
        chk("rst_acks", LW'({icache_addr_ok, dcache_addr_ok, icache_return_en, dcache_return_en}), 0);
        rst_n = 1'b1;
        tick();

        // Spurious return while idle
        mem_return_en   = 1'b1;
        mem_return_data = {8{32'hDEAD_BEEF}};
        #1;
        chk("spur_ret_en", LW'({icache_return_en, dcache_return_en}), 0);
        chk("spur_ic_data", icache_return_data, 0);
        chk("spur_dc_data", dcache_return_data, 0);
        chk("spur_busy", LW'(busy), 0);
        tick();
        mem_return_en   = 1'b0;
        mem_return_data = '0;
        #1;
        chk("spur_still_idle", LW'(busy), 0);

        // Both caches requesting continuously: strict alternation, icache first
        icache_req  = 1'b1;
        dcache_req  = 1'b1;
        icache_addr = 32'h0000_1234;
        dcache_addr = 32'h8000_00FF;
        push(1'b0, 32'h0000_1220, {32{8'h11}});
        push(1'b1, 32'h8000_00E0, {32{8'h22}});
        push(1'b0, 32'h0000_1220, {32{8'h33}});
        push(1'b1, 32'h8000_00E0, {32{8'h44}});
        repeat (4) serve(1'b1, 0, 0);
        icache_req = 1'b0;
        dcache_req = 1'b0;
        tick();

        // Single icache read with minimum latency and line alignment
        icache_req  = 1'b1;
        icache_addr = 32'h1C00_0014;
        push(1'b0, 32'h1C00_0000, {32{8'hA5}});
        tick();
        chk("min_latency_addr", LW'(mem_read_request), 1);
        serve(1'b0, 0, 0);
        tick();

        // dcache read with memory stalling acceptance for 5 cycles
        dcache_req  = 1'b1;
        dcache_addr = 32'hCAFE_F00D;
        push(1'b1, 32'hCAFE_F000, {8{32'h0BAD_F00D}});
        tick();
        serve(1'b0, 5, 0);
        tick();

        // DATA wait past TIMEOUT, then late completion
        icache_req  = 1'b1;
        icache_addr = 32'h0000_0FFF;
        push(1'b0, 32'h0000_0FE0, {16{16'h5A5A}});
        tick();
        serve(1'b0, 0, 13);
        tick();
        chk("timeout_sticky", LW'(timeout_err), 1);

        // Reset in the middle of a DATA phase
        dcache_req  = 1'b1;
        dcache_addr = 32'h4000_0040;
        tick();
        chk("abort_addr_busy", LW'(busy), 1);
        chk("abort_addr_grant", LW'(grant_id), 1);
        mem_ready_to_read = 1'b1;
        mem_read_addr_ok  = 1'b1;
        tick();
        mem_ready_to_read = 1'b0;
        mem_read_addr_ok  = 1'b0;
        dcache_req        = 1'b0;
        #1;
        chk("abort_data_busy", LW'(busy), 1);
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("abort_rst_busy", LW'(busy), 0);
        chk("abort_rst_grant", LW'(grant_id), 0);
        chk("abort_rst_err", LW'(timeout_err), 0);
        chk("abort_rst_req", LW'(mem_read_request), 0);
        tick();
        rst_n           = 1'b1;
        mem_return_en   = 1'b1;
        mem_return_data = '1;
        #1;
        chk("stale_ret_en", LW'({icache_return_en, dcache_return_en}), 0);
        chk("stale_dc_data", dcache_return_data, 0);
        chk("stale_busy", LW'(busy), 0);
        tick();
        mem_return_en   = 1'b0;
        mem_return_data = '0;

        // Pointer back to icache after reset
        icache_req  = 1'b1;
        dcache_req  = 1'b1;
        icache_addr = 32'h0000_2020;
        dcache_addr = 32'h0000_3030;
        push(1'b0, 32'h0000_2020, {32{8'h66}});
        push(1'b1, 32'h0000_3020, {32{8'h77}});
        tick();
        serve(1'b1, 0, 0);
        serve(1'b1, 0, 0);
        icache_req = 1'b0;
        dcache_req = 1'b0;
        tick();

        chk("sb_drained", LW'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
